// File: rtl/uart_packet_framer.sv
// rtl/uart_packet_framer.sv - buffers controller packets and frames them onto a byte-wide UART handshake
//
// Captures an 8*NUM_BYTES packet on each pkt_valid pulse into a DEPTH-entry FIFO,
// then sends each packet as [HEADER_BYTE] payload[0..NUM_BYTES-1] [XOR checksum]
// using the UART transmitter's tx_trmt / tx_data / tx_done handshake.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   pkt_data   in   packet payload, sampled only while pkt_valid=1
//   pkt_valid  in   single-cycle new-packet pulse
//   tx_done    in   UART byte-complete pulse
//   tx_trmt    out  registered start-byte pulse to the UART
//   tx_data    out  registered byte to the UART, held until the next start pulse
//   busy       out  frame in flight or packets still buffered
//   drop_cnt   out  saturating count of packets lost to a full buffer

module uart_packet_framer #(
    parameter int         NUM_BYTES   = 4,
    parameter int         DEPTH       = 2,
    parameter int         HEADER_EN   = 1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         CHKSUM_EN   = 1,
    parameter int         MSB_FIRST   = 0,
    parameter int         DROP_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_BYTES-1:0] pkt_data,
    input  logic                   pkt_valid,
    input  logic                   tx_done,
    output logic                   tx_trmt,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int PKT_W     = 8 * NUM_BYTES;
    localparam int HDR       = (HEADER_EN != 0) ? 1 : 0;
    localparam int CHK       = (CHKSUM_EN != 0) ? 1 : 0;
    localparam int FRAME_LEN = NUM_BYTES + HDR + CHK;
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [PKT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               wr;
    logic               pop;
    logic               advance;

    logic [PKT_W-1:0]   frame;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         chk_acc;

    // Source of the byte about to be issued: the FIFO head when starting a
    // frame (the frame register is loaded on the same edge), else the frame.
    logic [PKT_W-1:0]   src_data;
    logic [IDX_W-1:0]   src_idx;
    logic [7:0]         next_byte;
    logic               next_is_payload;

    // A full buffer still accepts a packet when the FSM frees a slot that cycle.
    assign wr   = pkt_valid && ((count < CNT_W'(DEPTH)) || pop);
    assign busy = (state != IDLE) || (count != '0);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        advance    = 1'b0;
        src_data   = frame;
        src_idx    = idx + 1'b1;
        case (state)
            IDLE: begin
                src_data = mem[rd_ptr];
                src_idx  = '0;
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (idx != IDX_W'(FRAME_LEN - 1)) begin
                        advance    = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame position -> byte. Positions past the payload hold the checksum,
    // which by then has accumulated every payload byte.
    always_comb begin
        next_byte       = chk_acc;
        next_is_payload = 1'b0;
        if (HDR == 1 && src_idx == '0) begin
            next_byte = HEADER_BYTE;
        end else begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (int'(src_idx) == k + HDR) begin
                    next_is_payload = 1'b1;
                    next_byte       = src_data[8*((MSB_FIRST != 0) ? (NUM_BYTES - 1 - k) : k) +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= pkt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_trmt  <= 1'b0;
            tx_data  <= '0;
            frame    <= '0;
            idx      <= '0;
            chk_acc  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            state   <= state_next;
            tx_trmt <= (state_next == ISSUE);
            if (state_next == ISSUE) begin
                tx_data <= next_byte;
            end

            if (pop) begin
                frame   <= mem[rd_ptr];
                idx     <= '0;
                chk_acc <= next_is_payload ? next_byte : 8'h00;
            end else if (advance) begin
                idx <= idx + 1'b1;
                if (next_is_payload) begin
                    chk_acc <= chk_acc ^ next_byte;
                end
            end

            if (wr) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pkt_valid && !wr && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_framer.sv
// tb/tb_uart_packet_framer.sv - self-checking bench for uart_packet_framer (default and MSB-first/bare configs)

module tb_uart_packet_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pkt_data;
    logic        pv0, pv1;
    logic        done0, done1;
    logic        trmt0, trmt1;
    logic [7:0]  txd0, txd1;
    logic        busy0, busy1;
    logic [7:0]  drop0, drop1;

    int          cyc = 0;
    int          nvec = 0;
    int          nfail = 0;
    int          dly = 10;
    bit          hold0 = 1'b0;
    bit          hold1 = 1'b0;
    int          ndone0 = 0;
    int          ndone1 = 0;
    int          drop_exp = 0;
    int          base [2];

    logic [7:0]  obs0 [$];
    logic [7:0]  obs1 [$];
    int          tcyc0 [$];
    int          tcyc1 [$];
    logic [7:0]  exp0 [$];
    logic [7:0]  exp1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_packet_framer dut0 (
        .clk(clk), .rst_n(rst_n), .pkt_data(pkt_data), .pkt_valid(pv0), .tx_done(done0),
        .tx_trmt(trmt0), .tx_data(txd0), .busy(busy0), .drop_cnt(drop0)
    );

    uart_packet_framer #(.HEADER_EN(0), .CHKSUM_EN(0), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pkt_data(pkt_data), .pkt_valid(pv1), .tx_done(done1),
        .tx_trmt(trmt1), .tx_data(txd1), .busy(busy1), .drop_cnt(drop1)
    );

    // UART models: capture each started byte, answer with tx_done dly cycles later
    initial begin : resp0
        done0 = 1'b0;
        @(negedge clk);
        forever begin
            if (rst_n && trmt0) begin
                obs0.push_back(txd0);
                tcyc0.push_back(cyc);
                repeat (dly) @(negedge clk);
                while (hold0) @(negedge clk);
                done0 = 1'b1;
                ndone0++;
                @(negedge clk);
                done0 = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : resp1
        done1 = 1'b0;
        @(negedge clk);
        forever begin
            if (rst_n && trmt1) begin
                obs1.push_back(txd1);
                tcyc1.push_back(cyc);
                repeat (dly) @(negedge clk);
                while (hold1) @(negedge clk);
                done1 = 1'b1;
                ndone1++;
                @(negedge clk);
                done1 = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    function automatic int obs_sz(input int k);
        return (k == 0) ? obs0.size() : obs1.size();
    endfunction

    function automatic logic [7:0] obs_at(input int k, input int i);
        return (k == 0) ? obs0[i] : obs1[i];
    endfunction

    function automatic int exp_sz(input int k);
        return (k == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic logic [7:0] exp_at(input int k, input int i);
        return (k == 0) ? exp0[i] : exp1[i];
    endfunction

    // Reference framing: dut0 = header + LSB-first payload + XOR; dut1 = MSB-first payload only
    function automatic void add_pkt(input logic [31:0] p);
        logic [7:0] b [4];
        logic [7:0] chk;
        chk = 8'h00;
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'((p >> (8 * i)) & 32'hFF);
            chk  = chk ^ b[i];
        end
        exp0.push_back(8'hA5);
        for (int i = 0; i < 4; i++) exp0.push_back(b[i]);
        exp0.push_back(chk);
        for (int i = 0; i < 4; i++) exp1.push_back(b[3 - i]);
    endfunction

    task automatic start_test();
        base[0] = obs0.size();
        base[1] = obs1.size();
        exp0.delete();
        exp1.delete();
    endtask

    task automatic send(input logic [31:0] p, input bit to0, input bit to1);
        pkt_data = p;
        pv0 = to0;
        pv1 = to1;
        @(negedge clk);
        pv0 = 1'b0;
        pv1 = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy0 && !busy1 && !done0 && !done1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pv0 = 1'b0;
        pv1 = 1'b0;
        pkt_data = '0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({trmt0, txd0, busy0, drop0} !== 18'h0) begin
            nfail++;
            $display("FAIL reset_dut0: trmt=%0b data=%02h busy=%0b drop=%0d, want all 0", trmt0, txd0, busy0, drop0);
        end
        nvec++;
        if ({trmt1, txd1, busy1, drop1} !== 18'h0) begin
            nfail++;
            $display("FAIL reset_dut1: trmt=%0b data=%02h busy=%0b drop=%0d, want all 0", trmt1, txd1, busy1, drop1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if ({busy0, busy1, trmt0, trmt1} !== 4'b0) begin
            nfail++;
            $display("FAIL reset_idle: busy=%0b%0b trmt=%0b%0b, want 0", busy0, busy1, trmt0, trmt1);
        end
    endtask

    task automatic test_basic();
        int  pcyc;
        int  nd;
        bit  ok;
        start_test();
        nd = ndone0;
        add_pkt(32'h44332211);
        pcyc = cyc;
        send(32'h44332211, 1'b1, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            #1;
            if (ndone0 >= nd + 6) begin
                ok = 1'b1;
                break;
            end
        end
        nvec++;
        if (ok !== 1'b1) begin
            nfail++;
            $display("FAIL basic_done_timeout: got %0d tx_done, want 6", ndone0 - nd);
        end
        nvec++;
        if (busy0 !== 1'b1) begin
            nfail++;
            $display("FAIL basic_busy_last_done: got %0b, want 1", busy0);
        end
        @(negedge clk);
        nvec++;
        if (busy0 !== 1'b0) begin
            nfail++;
            $display("FAIL basic_busy_fall: got %0b, want 0", busy0);
        end
        wait_idle(ok);
        nvec++;
        if (ok !== 1'b1) begin
            nfail++;
            $display("FAIL basic_idle_timeout: busy=%0b%0b, want 00", busy0, busy1);
        end
        nvec++;
        if (tcyc0.size() <= base[0] || tcyc0[base[0]] !== pcyc + 2) begin
            nfail++;
            $display("FAIL basic_latency_dut0: got first trmt at cycle %0d, want %0d",
                     (tcyc0.size() > base[0]) ? tcyc0[base[0]] : -1, pcyc + 2);
        end
        nvec++;
        if (tcyc1.size() <= base[1] || tcyc1[base[1]] !== pcyc + 2) begin
            nfail++;
            $display("FAIL basic_latency_dut1: got first trmt at cycle %0d, want %0d",
                     (tcyc1.size() > base[1]) ? tcyc1[base[1]] : -1, pcyc + 2);
        end
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs_sz(k) - base[k] !== exp_sz(k)) begin
                nfail++;
                $display("FAIL basic_len dut%0d: got %0d bytes, want %0d", k, obs_sz(k) - base[k], exp_sz(k));
            end else begin
                for (int i = 0; i < exp_sz(k); i++) begin
                    nvec++;
                    if (obs_at(k, base[k] + i) !== exp_at(k, i)) begin
                        nfail++;
                        $display("FAIL basic_byte dut%0d[%0d]: got %02h, want %02h", k, i, obs_at(k, base[k] + i), exp_at(k, i));
                    end
                end
            end
        end
    endtask

    task automatic test_data_hold();
        bit ok;
        start_test();
        add_pkt(32'h44332211);
        send(32'h44332211, 1'b1, 1'b1);
        pkt_data = 32'hDEADBEEF;
        wait_idle(ok);
        nvec++;
        if (ok !== 1'b1) begin
            nfail++;
            $display("FAIL hold_idle_timeout: busy=%0b%0b, want 00", busy0, busy1);
        end
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs_sz(k) - base[k] !== exp_sz(k)) begin
                nfail++;
                $display("FAIL hold_len dut%0d: got %0d bytes, want %0d", k, obs_sz(k) - base[k], exp_sz(k));
            end else begin
                for (int i = 0; i < exp_sz(k); i++) begin
                    nvec++;
                    if (obs_at(k, base[k] + i) !== exp_at(k, i)) begin
                        nfail++;
                        $display("FAIL hold_byte dut%0d[%0d]: got %02h, want %02h", k, i, obs_at(k, base[k] + i), exp_at(k, i));
                    end
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] p;
        bit          ok;
        start_test();
        hold0 = 1'b1;
        hold1 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            p = $urandom;
            if (j < 3) add_pkt(p);
            send(p, 1'b1, 1'b1);
        end
        drop_exp = drop_exp + 1;
        repeat (2) @(negedge clk);
        nvec++;
        if (drop0 !== 8'(drop_exp) || drop1 !== 8'(drop_exp)) begin
            nfail++;
            $display("FAIL overflow_drop: got %0d/%0d, want %0d", drop0, drop1, drop_exp);
        end
        hold0 = 1'b0;
        hold1 = 1'b0;
        wait_idle(ok);
        nvec++;
        if (ok !== 1'b1) begin
            nfail++;
            $display("FAIL overflow_idle_timeout: busy=%0b%0b, want 00", busy0, busy1);
        end
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs_sz(k) - base[k] !== exp_sz(k)) begin
                nfail++;
                $display("FAIL overflow_len dut%0d: got %0d bytes, want %0d", k, obs_sz(k) - base[k], exp_sz(k));
            end else begin
                for (int i = 0; i < exp_sz(k); i++) begin
                    nvec++;
                    if (obs_at(k, base[k] + i) !== exp_at(k, i)) begin
                        nfail++;
                        $display("FAIL overflow_byte dut%0d[%0d]: got %02h, want %02h", k, i, obs_at(k, base[k] + i), exp_at(k, i));
                    end
                end
            end
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] p [4];
        int          nd;
        bit          ok;
        start_test();
        for (int j = 0; j < 4; j++) begin
            p[j] = $urandom;
            add_pkt(p[j]);
        end
        hold0 = 1'b1;
        hold1 = 1'b1;
        for (int j = 0; j < 3; j++) send(p[j], 1'b1, 1'b1);
        // Release one DUT at a time and hit it with pkt_valid in its pop cycle
        for (int k = 0; k < 2; k++) begin
            nd = (k == 0) ? ndone0 : ndone1;
            if (k == 0) hold0 = 1'b0;
            else hold1 = 1'b0;
            ok = 1'b0;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                #1;
                if (((k == 0) ? ndone0 : ndone1) >= nd + ((k == 0) ? 6 : 4)) begin
                    ok = 1'b1;
                    break;
                end
            end
            nvec++;
            if (ok !== 1'b1) begin
                nfail++;
                $display("FAIL fullpop_timeout dut%0d: frame end not seen, want it within 500 cycles", k);
            end
            @(negedge clk);
            send(p[3], k == 0, k == 1);
        end
        wait_idle(ok);
        nvec++;
        if (ok !== 1'b1) begin
            nfail++;
            $display("FAIL fullpop_idle_timeout: busy=%0b%0b, want 00", busy0, busy1);
        end
        nvec++;
        if (drop0 !== 8'(drop_exp) || drop1 !== 8'(drop_exp)) begin
            nfail++;
            $display("FAIL fullpop_drop: got %0d/%0d, want %0d", drop0, drop1, drop_exp);
        end
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs_sz(k) - base[k] !== exp_sz(k)) begin
                nfail++;
                $display("FAIL fullpop_len dut%0d: got %0d bytes, want %0d", k, obs_sz(k) - base[k], exp_sz(k));
            end else begin
                for (int i = 0; i < exp_sz(k); i++) begin
                    nvec++;
                    if (obs_at(k, base[k] + i) !== exp_at(k, i)) begin
                        nfail++;
                        $display("FAIL fullpop_byte dut%0d[%0d]: got %02h, want %02h", k, i, obs_at(k, base[k] + i), exp_at(k, i));
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] p;
        int          n;
        bit          ok;
        start_test();
        for (int b = 0; b < 8; b++) begin
            dly = $urandom_range(1, 12);
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                p = $urandom;
                add_pkt(p);
                send(p, 1'b1, 1'b1);
            end
            wait_idle(ok);
            nvec++;
            if (ok !== 1'b1) begin
                nfail++;
                $display("FAIL random_idle_timeout burst %0d: busy=%0b%0b, want 00", b, busy0, busy1);
            end
        end
        dly = 10;
        nvec++;
        if (drop0 !== 8'(drop_exp) || drop1 !== 8'(drop_exp)) begin
            nfail++;
            $display("FAIL random_drop: got %0d/%0d, want %0d", drop0, drop1, drop_exp);
        end
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs_sz(k) - base[k] !== exp_sz(k)) begin
                nfail++;
                $display("FAIL random_len dut%0d: got %0d bytes, want %0d", k, obs_sz(k) - base[k], exp_sz(k));
            end else begin
                for (int i = 0; i < exp_sz(k); i++) begin
                    nvec++;
                    if (obs_at(k, base[k] + i) !== exp_at(k, i)) begin
                        nfail++;
                        $display("FAIL random_byte dut%0d[%0d]: got %02h, want %02h", k, i, obs_at(k, base[k] + i), exp_at(k, i));
                    end
                end
            end
        end
    endtask

    task automatic test_saturate();
        logic [31:0] p;
        bit          ok;
        start_test();
        hold0 = 1'b1;
        hold1 = 1'b1;
        // First three packets are taken (one in flight, two buffered), the rest dropped
        for (int j = 0; j < 305; j++) begin
            p = $urandom;
            if (j < 3) add_pkt(p);
            send(p, 1'b1, 1'b1);
        end
        drop_exp = (drop_exp + 302 > 255) ? 255 : drop_exp + 302;
        @(negedge clk);
        nvec++;
        if (drop0 !== 8'(drop_exp) || drop1 !== 8'(drop_exp)) begin
            nfail++;
            $display("FAIL saturate_drop: got %0d/%0d, want %0d", drop0, drop1, drop_exp);
        end
        hold0 = 1'b0;
        hold1 = 1'b0;
        wait_idle(ok);
        nvec++;
        if (ok !== 1'b1) begin
            nfail++;
            $display("FAIL saturate_idle_timeout: busy=%0b%0b, want 00", busy0, busy1);
        end
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs_sz(k) - base[k] !== exp_sz(k)) begin
                nfail++;
                $display("FAIL saturate_len dut%0d: got %0d bytes, want %0d", k, obs_sz(k) - base[k], exp_sz(k));
            end else begin
                for (int i = 0; i < exp_sz(k); i++) begin
                    nvec++;
                    if (obs_at(k, base[k] + i) !== exp_at(k, i)) begin
                        nfail++;
                        $display("FAIL saturate_byte dut%0d[%0d]: got %02h, want %02h", k, i, obs_at(k, base[k] + i), exp_at(k, i));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] p;
        int          s0, s1;
        bit          ok;
        s0 = obs0.size();
        send($urandom, 1'b1, 1'b1);
        send($urandom, 1'b1, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            #1;
            if (obs0.size() >= s0 + 2) begin
                ok = 1'b1;
                break;
            end
        end
        nvec++;
        if (ok !== 1'b1) begin
            nfail++;
            $display("FAIL midreset_timeout: got %0d trmt, want 2", obs0.size() - s0);
        end
        rst_n = 1'b0;
        drop_exp = 0;
        #1;
        nvec++;
        if ({trmt0, txd0, busy0, drop0} !== 18'h0 || {trmt1, txd1, busy1, drop1} !== 18'h0) begin
            nfail++;
            $display("FAIL midreset_async: dut0 %0b/%02h/%0b/%0d dut1 %0b/%02h/%0b/%0d, want all 0",
                     trmt0, txd0, busy0, drop0, trmt1, txd1, busy1, drop1);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s0 = obs0.size();
        s1 = obs1.size();
        repeat (30) @(negedge clk);
        nvec++;
        if (obs0.size() !== s0 || obs1.size() !== s1 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
            nfail++;
            $display("FAIL midreset_quiet: got %0d/%0d new trmt busy=%0b%0b, want 0/0 busy=00",
                     obs0.size() - s0, obs1.size() - s1, busy0, busy1);
        end
        start_test();
        p = $urandom;
        add_pkt(p);
        send(p, 1'b1, 1'b1);
        wait_idle(ok);
        nvec++;
        if (ok !== 1'b1) begin
            nfail++;
            $display("FAIL midreset_idle_timeout: busy=%0b%0b, want 00", busy0, busy1);
        end
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs_sz(k) - base[k] !== exp_sz(k)) begin
                nfail++;
                $display("FAIL midreset_len dut%0d: got %0d bytes, want %0d", k, obs_sz(k) - base[k], exp_sz(k));
            end else begin
                for (int i = 0; i < exp_sz(k); i++) begin
                    nvec++;
                    if (obs_at(k, base[k] + i) !== exp_at(k, i)) begin
                        nfail++;
                        $display("FAIL midreset_byte dut%0d[%0d]: got %02h, want %02h", k, i, obs_at(k, base[k] + i), exp_at(k, i));
                    end
                end
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want completion within 2 ms");
        $fatal(1);
    end

    initial begin : main
        test_reset();
        @(negedge clk);
        test_basic();
        test_data_hold();
        test_overflow();
        test_full_pop();
        test_random();
        test_saturate();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/uart_packet_framer.md
Name: uart_packet_framer

Overview:
- Parametrised successor to the fixed 4-byte controller-to-UART sender.
- Captures a controller packet of NUM_BYTES bytes on a valid pulse into a DEPTH-entry packet buffer, so the source does not have to hold its data.
- Serialises each packet onto a byte-wide UART transmitter handshake (tx_trmt/tx_data/tx_done), with an optional header byte, selectable byte order and an optional XOR checksum trailer.
- Sits between the controller poller and the UART transmitter in the host link path.

Parameters:
- NUM_BYTES, 4, payload bytes per packet (1..16).
- DEPTH, 2, packet buffer entries (1..8).
- HEADER_EN, 1, 1 = send HEADER_BYTE before the payload.
- HEADER_BYTE, 8'hA5, sync byte value.
- CHKSUM_EN, 1, 1 = send an XOR-of-payload byte after the payload.
- MSB_FIRST, 0, 0 = byte [7:0] first; 1 = top byte first.
- DROP_W, 8, drop counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- pkt_data  in  8*NUM_BYTES  packet payload, sampled only when pkt_valid=1
- pkt_valid  in  1  single-cycle "new packet" pulse
- tx_done  in  1  UART byte-complete pulse
- tx_trmt  out  1  start-byte pulse to the UART
- tx_data  out  8  byte to the UART
- busy  out  1  high while a frame is in flight or the buffer is non-empty
- drop_cnt  out  DROP_W  saturating count of dropped packets

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: tx_trmt=0, tx_data=0, busy=0, drop_cnt=0, buffer empty, FSM in IDLE.
- Buffer:
  - Circular FIFO of DEPTH x 8*NUM_BYTES.
  - pkt_valid writes pkt_data if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the packet is dropped and drop_cnt increments, saturating at all-ones.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If the buffer is non-empty, pop the head into a frame register.
  - Clear the byte index and the checksum accumulator, then go to ISSUE.
- ISSUE:
  - For exactly one cycle: tx_trmt=1 and tx_data = current frame byte; go to WAIT.
  - tx_trmt and tx_data are registered outputs.
  - tx_data holds its value until the next ISSUE.
- Frame byte sequence:
  - [HEADER_BYTE if HEADER_EN].
  - Then the payload bytes 0..NUM_BYTES-1. Payload byte k = pkt_data[8k+7:8k] when MSB_FIRST=0, otherwise byte NUM_BYTES-1-k.
  - Then [chk if CHKSUM_EN], where chk = XOR of all payload bytes; the header is excluded.
- WAIT:
  - tx_done is ignored in the cycle tx_trmt is high.
  - On a later tx_done: if bytes remain, advance the index and go to ISSUE; otherwise go to IDLE.
  - Inter-byte gap is 1 cycle: tx_trmt rises the cycle after tx_done is sampled.
- tx_done outside WAIT is ignored.
- Latency: with IDLE and an empty buffer, pkt_valid in cycle 0 gives the first tx_trmt in cycle 2.
- Back-to-back frames: IDLE lasts one cycle between the final tx_done and the next frame's ISSUE.
- busy = (state != IDLE) or (count != 0).
- Simultaneous pkt_valid and pop on an empty buffer: not possible, because a pop requires count>0. The newly written packet is visible the next cycle.
- Reset mid-frame: the frame is aborted immediately and the buffer is flushed. No further tx_trmt is issued until a new pkt_valid arrives.

Test Plan:
- Defaults, pkt_data=32'h44332211, one pkt_valid, UART model asserts tx_done 10 cycles after each trmt -> bytes A5,11,22,33,44,44. First trmt 2 cycles after pkt_valid. busy falls 1 cycle after the 6th tx_done.
- MSB_FIRST=1, same data -> A5,44,33,22,11,44. With HEADER_EN=0 and CHKSUM_EN=0 -> 44,33,22,11 only.
- Data-hold check: change pkt_data to 32'hDEADBEEF the cycle after pkt_valid -> the transmitted payload is still 11,22,33,44.
- Overflow, DEPTH=2: four pkt_valid pulses on consecutive cycles, tx_done withheld -> packet 1 in flight, packets 2 and 3 buffered, packet 4 dropped, drop_cnt=1. Releasing tx_done then sends packets 1, 2 and 3 in order.
- Full plus pop at once: buffer full and the FSM pops in the same cycle as pkt_valid -> packet accepted, drop_cnt unchanged. drop_cnt saturates at 255 after 300 drops.
- Reset mid-frame: assert rst_n=0 after the 2nd byte's trmt -> all outputs reset asynchronously, no further trmt, busy=0. A new packet after release gives a full, correct frame.
